// File: rtl/mult_pkg.sv
// Shared definitions for the repeated-addition multiplier (datapath and control FSM).
package mult_pkg;

  localparam int MULT_WIDTH  = 16;
  localparam int MULT_PWIDTH = 2 * MULT_WIDTH;

  // Control strobes issued by the FSM each cycle.
  typedef struct packed {
    logic lda;
    logic ldb;
    logic clrp;
    logic ldp;
    logic decb;
  } strobe_t;

endpackage

// File: rtl/mult_datapath_if.sv
// Bus between the multiplier control FSM (master) and the datapath (slave).
interface mult_datapath_if
  import mult_pkg::*;
#(
  parameter int WIDTH  = MULT_WIDTH,
  parameter int PWIDTH = MULT_PWIDTH
) ();

  logic [WIDTH-1:0]  data_in;
  strobe_t           strb;
  logic              eqz;
  logic [PWIDTH-1:0] prod;
  logic              ovf;

  modport master (output data_in, strb, input  eqz, prod, ovf);
  modport slave  (input  data_in, strb, output eqz, prod, ovf);

endinterface

// File: rtl/mult_down_counter.sv
// Multiplier/loop counter B: parallel load, saturating decrement, zero flag.
module mult_down_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] cnt,
  output logic             zero
);

  // Decrement that sticks at zero instead of wrapping.
  function automatic logic [WIDTH-1:0] sat_dec(input logic [WIDTH-1:0] x);
    return (x == '0) ? x : x - 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= din;
    end else if (dec) begin
      cnt <= sat_dec(cnt);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mult_datapath.sv
// Repeated-addition multiplier datapath: A, B (down counter) and accumulator P.
// PWIDTH must be at least WIDTH; below 2*WIDTH the product can wrap and sets ovf.
module mult_datapath
  import mult_pkg::*;
#(
  parameter int WIDTH  = MULT_WIDTH,
  parameter int PWIDTH = MULT_PWIDTH
) (
  input logic            clk,
  input logic            rst_n,
  mult_datapath_if.slave bus
);

  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [PWIDTH-1:0] p_q;
  logic              ovf_q;
  logic              eqz;
  logic [PWIDTH:0]   sum;

  // Untruncated P + A; the extra top bit is the carry out of PWIDTH.
  function automatic logic [PWIDTH:0] acc_add(input logic [PWIDTH-1:0] p,
                                              input logic [WIDTH-1:0]  a);
    return {1'b0, p} + {{(PWIDTH + 1 - WIDTH){1'b0}}, a};
  endfunction

  mult_down_counter #(.WIDTH(WIDTH)) u_bcnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (bus.strb.ldb),
    .dec   (bus.strb.decb),
    .din   (bus.data_in),
    .cnt   (b_q),
    .zero  (eqz)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
    end else if (bus.strb.lda) begin
      a_q <= bus.data_in;
    end
  end

  assign sum = acc_add(p_q, a_q);

  // eqz here is the pre-edge B, so a zero multiplier never accumulates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q   <= '0;
      ovf_q <= 1'b0;
    end else if (bus.strb.clrp) begin
      p_q   <= '0;
      ovf_q <= 1'b0;
    end else if (bus.strb.ldp && !eqz) begin
      p_q <= sum[PWIDTH-1:0];
      if (sum[PWIDTH]) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign bus.eqz  = eqz;
  assign bus.prod = p_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_mult_datapath.sv
// Directed bench for mult_datapath: two 16/32 instances and one 8/8 instance.
module tb_mult_datapath;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  mult_datapath_if #(.WIDTH(16), .PWIDTH(32)) bus16  ();
  mult_datapath_if #(.WIDTH(16), .PWIDTH(32)) bus16b ();
  mult_datapath_if #(.WIDTH(8),  .PWIDTH(8))  bus8   ();

  mult_datapath #(.WIDTH(16), .PWIDTH(32)) u16  (.clk(clk), .rst_n(rst_n), .bus(bus16));
  mult_datapath #(.WIDTH(16), .PWIDTH(32)) u16b (.clk(clk), .rst_n(rst_n), .bus(bus16b));
  mult_datapath #(.WIDTH(8),  .PWIDTH(8))  u8   (.clk(clk), .rst_n(rst_n), .bus(bus8));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus16.strb  = '0;
    bus16b.strb = '0;
    bus8.strb   = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc16(input logic [15:0] d, input logic a, b, c, p, e);
    bus16.data_in = d;
    bus16.strb    = '{lda: a, ldb: b, clrp: c, ldp: p, decb: e};
    tick();
    idle();
  endtask

  task automatic cyc8(input logic [7:0] d, input logic a, b, c, p, e);
    bus8.data_in = d;
    bus8.strb    = '{lda: a, ldb: b, clrp: c, ldp: p, decb: e};
    tick();
    idle();
  endtask

  initial begin
    bus16.data_in  = '0;
    bus16b.data_in = '0;
    bus8.data_in   = '0;
    idle();
    repeat (2) tick();
    chk("rst_prod", 64'(bus16.prod), 64'd0);
    chk("rst_ovf",  64'(bus16.ovf),  64'd0);
    chk("rst_eqz",  64'(bus16.eqz),  64'd1);
    chk("rst_eqz8", 64'(bus8.eqz),   64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // nominal 7 * 5
    cyc16(16'd7, 1, 0, 0, 0, 0);
    cyc16(16'd5, 0, 1, 1, 0, 0);
    chk("nom_eqz_loaded", 64'(bus16.eqz), 64'd0);
    repeat (4) cyc16(16'd0, 0, 0, 0, 1, 1);
    chk("nom_prod_4", 64'(bus16.prod), 64'd28);
    chk("nom_eqz_4",  64'(bus16.eqz),  64'd0);
    cyc16(16'd0, 0, 0, 0, 1, 1);
    chk("nom_prod_5", 64'(bus16.prod), 64'd35);
    chk("nom_eqz_5",  64'(bus16.eqz),  64'd1);
    chk("nom_ovf",    64'(bus16.ovf),  64'd0);
    cyc16(16'd0, 0, 0, 0, 1, 1);
    chk("nom_gated_hold", 64'(bus16.prod), 64'd35);

    // new A mid-loop: 7 + 7 + 10
    cyc16(16'd3, 0, 1, 1, 0, 0);
    cyc16(16'd0, 0, 0, 0, 1, 1);
    cyc16(16'd10, 1, 0, 0, 1, 1);
    cyc16(16'd0, 0, 0, 0, 1, 1);
    chk("midA_prod", 64'(bus16.prod), 64'd24);
    chk("midA_eqz",  64'(bus16.eqz),  64'd1);

    // zero multiplier
    cyc16(16'd9, 1, 0, 0, 0, 0);
    cyc16(16'd0, 0, 1, 1, 0, 0);
    chk("zb_eqz_loaded", 64'(bus16.eqz), 64'd1);
    for (int i = 0; i < 3; i++) begin
      cyc16(16'd0, 0, 0, 0, 1, 1);
      chk("zb_prod", 64'(bus16.prod), 64'd0);
      chk("zb_eqz",  64'(bus16.eqz),  64'd1);
    end

    // clrp beats ldp
    cyc16(16'd2, 0, 1, 0, 0, 0);
    cyc16(16'd0, 0, 0, 0, 1, 1);
    chk("pri_prod_pre", 64'(bus16.prod), 64'd9);
    cyc16(16'd0, 0, 0, 1, 1, 1);
    chk("pri_clrp_ldp", 64'(bus16.prod), 64'd0);
    chk("pri_clrp_eqz", 64'(bus16.eqz),  64'd1);

    // ldb beats decb: B must be 4, so 9*4
    cyc16(16'd4, 0, 1, 0, 0, 1);
    repeat (3) cyc16(16'd0, 0, 0, 0, 1, 1);
    chk("pri_ldb_eqz3", 64'(bus16.eqz),  64'd0);
    chk("pri_ldb_p3",   64'(bus16.prod), 64'd27);
    cyc16(16'd0, 0, 0, 0, 1, 1);
    chk("pri_ldb_p4",   64'(bus16.prod), 64'd36);

    // async reset mid-loop with B=3
    cyc16(16'd3, 0, 1, 1, 0, 0);
    cyc16(16'd0, 0, 0, 0, 1, 1);
    chk("mr_prod_pre", 64'(bus16.prod), 64'd9);
    bus16.strb = '{lda: 1'b0, ldb: 1'b0, clrp: 1'b0, ldp: 1'b1, decb: 1'b1};
    #3 rst_n = 1'b0;
    #1;
    chk("mr_prod", 64'(bus16.prod), 64'd0);
    chk("mr_eqz",  64'(bus16.eqz),  64'd1);
    chk("mr_ovf",  64'(bus16.ovf),  64'd0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    cyc16(16'd2, 0, 1, 1, 0, 0);
    repeat (2) cyc16(16'd0, 0, 0, 0, 1, 1);
    chk("mr_a_cleared", 64'(bus16.prod), 64'd0);
    chk("mr_eqz_after", 64'(bus16.eqz),  64'd1);

    // lda and ldb on the same edge: 3*3
    cyc16(16'd3, 1, 1, 1, 0, 0);
    repeat (3) cyc16(16'd0, 0, 0, 0, 1, 1);
    chk("ldab_prod", 64'(bus16.prod), 64'd9);
    chk("ldab_eqz",  64'(bus16.eqz),  64'd1);

    // 0 * 0xFFFF and 0xFFFF * 0xFFFF in parallel
    bus16.data_in  = 16'h0000;
    bus16b.data_in = 16'hFFFF;
    bus16.strb     = '{lda: 1'b1, ldb: 1'b0, clrp: 1'b0, ldp: 1'b0, decb: 1'b0};
    bus16b.strb    = '{lda: 1'b1, ldb: 1'b0, clrp: 1'b0, ldp: 1'b0, decb: 1'b0};
    tick();
    bus16.data_in  = 16'hFFFF;
    bus16.strb     = '{lda: 1'b0, ldb: 1'b1, clrp: 1'b1, ldp: 1'b0, decb: 1'b0};
    bus16b.strb    = '{lda: 1'b0, ldb: 1'b1, clrp: 1'b1, ldp: 1'b0, decb: 1'b0};
    tick();
    bus16.strb     = '{lda: 1'b0, ldb: 1'b0, clrp: 1'b0, ldp: 1'b1, decb: 1'b1};
    bus16b.strb    = '{lda: 1'b0, ldb: 1'b0, clrp: 1'b0, ldp: 1'b1, decb: 1'b1};
    repeat (65534) tick();
    chk("max_eqz_early", 64'(bus16b.eqz), 64'd0);
    tick();
    idle();
    chk("zmax_prod", 64'(bus16.prod),  64'd0);
    chk("zmax_eqz",  64'(bus16.eqz),   64'd1);
    chk("max_prod",  64'(bus16b.prod), 64'hFFFE_0001);
    chk("max_eqz",   64'(bus16b.eqz),  64'd1);
    chk("max_ovf",   64'(bus16b.ovf),  64'd0);

    // 8/8 wrap: 200*2 = 400 -> 144 with ovf
    cyc8(8'd200, 1, 0, 0, 0, 0);
    cyc8(8'd2,   0, 1, 1, 0, 0);
    cyc8(8'd0,   0, 0, 0, 1, 1);
    chk("ov_prod_1", 64'(bus8.prod), 64'd200);
    chk("ov_ovf_1",  64'(bus8.ovf),  64'd0);
    cyc8(8'd0,   0, 0, 0, 1, 1);
    chk("ov_prod_2", 64'(bus8.prod), 64'd144);
    chk("ov_ovf_2",  64'(bus8.ovf),  64'd1);
    chk("ov_eqz_2",  64'(bus8.eqz),  64'd1);
    cyc8(8'd1,   1, 1, 0, 0, 0);
    cyc8(8'd0,   0, 0, 0, 1, 1);
    chk("ov_sticky_prod", 64'(bus8.prod), 64'd145);
    chk("ov_sticky_ovf",  64'(bus8.ovf),  64'd1);
    cyc8(8'd0,   0, 0, 1, 0, 0);
    chk("ov_clr_prod", 64'(bus8.prod), 64'd0);
    chk("ov_clr_ovf",  64'(bus8.ovf),  64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_datapath.md
Name: mult_datapath

Overview:
- Datapath for the repeated-addition multiplier; sits directly downstream of the multiplier control FSM.
- Consumes the control strobes lda, ldb, clrp, ldp and decb, and returns the status flag eqz.
- Holds multiplicand A, multiplier/loop counter B and product accumulator P.
- Operands arrive one at a time on a shared data_in bus; the product P is held until cleared or reset.

Parameters:
- WIDTH, 16, operand width of data_in, A and B.
- PWIDTH, 2*WIDTH, product width; must be at least WIDTH. Values below 2*WIDTH allow truncation, which is reported on ovf.

Ports:
- clk    input   1       rising-edge clock.
- rst_n  input   1       asynchronous, active-low reset.
- data_in input  WIDTH   shared operand bus, sampled on lda/ldb.
- lda    input   1       load A from data_in.
- ldb    input   1       load B from data_in.
- clrp   input   1       clear P and ovf.
- ldp    input   1       accumulate P <= P + A.
- decb   input   1       decrement B.
- eqz    output  1       combinational, (B == 0).
- prod   output  PWIDTH  current P register value.
- ovf    output  1       sticky, set when an accumulate carries out of PWIDTH.

Behaviour:
- Reset (rst_n low, asynchronous): A=0, B=0, P=0, ovf=0. Hence eqz=1 and prod=0 during and after reset.
- Registers update on the rising edge of clk only; there is no enable other than the strobes.
- A: on lda, A <= data_in. Otherwise hold.
- B:
  - On ldb, B <= data_in.
  - Else on decb with B != 0, B <= B-1.
  - Decb with B == 0 holds B at 0; B never wraps.
  - Ldb has priority over decb on the same edge.
- P:
  - Clrp has priority: P <= 0 and ovf <= 0, regardless of ldp.
  - Else on ldp with eqz==0: P <= P + zero-extended A, truncated to PWIDTH.
  - Ldp with eqz==1 holds P.
- Gating rule: eqz is evaluated from the pre-edge B value. This makes a zero multiplier yield P=0, and the FSM exit check (eqz after the edge) lands exactly after B additions.
- ovf: set on any ungated accumulate whose untruncated sum is at least 2^PWIDTH. It stays set until clrp or reset, and is never set when PWIDTH = 2*WIDTH.
- eqz: purely combinational from B, with no register stage. The FSM samples it after each edge in its loop state.
- Nominal sequence:
  1. lda cycle.
  2. ldb+clrp cycle.
  3. N cycles of ldp+decb.
  4. On the Nth edge, B reaches 0 and eqz rises. P = A*N, latency N+2 edges after lda.
- Loading A mid-loop (lda during ldp) is legal: accumulates after that edge use the new A.
- Reset mid-operation returns to reset values immediately, asynchronously. No partial product survives.
- lda and ldb asserted on the same edge both load data_in.
- Product wrap (PWIDTH < 2*WIDTH): P keeps the low PWIDTH bits and ovf is set.

Decomposition:
- Shared package mult_pkg:
  - default WIDTH/PWIDTH constants;
  - strobe-bundle typedef {lda, ldb, clrp, ldp, decb}, shared with the control FSM.
- One natural sub-module: mult_down_counter, holding B with load, saturating decrement and zero flag, parameterised by WIDTH.
- The A and P registers and the adder stay inline.

Test Plan:
- Reset: assert rst_n low mid-cycle -> prod=0, ovf=0, eqz=1 immediately, without waiting for a clock edge.
- Nominal multiply: lda with data_in=7, then ldb+clrp with data_in=5, then 5 cycles of ldp+decb -> eqz rises after the 5th edge, prod=35, ovf=0.
- Zero multiplier: A=9, B=0, then ldp+decb for 3 cycles -> P stays 0, B stays 0, eqz=1 throughout.
- Zero multiplicand / max multiplier: A=0, B=0xFFFF (WIDTH=16) -> after 65535 loop edges prod=0 and eqz=1. Also A=0xFFFF, B=0xFFFF -> prod=0xFFFE0001.
- Overflow (WIDTH=8, PWIDTH=8): A=200, B=2 -> after 2 edges prod=144 and ovf=1. A subsequent clrp gives prod=0, ovf=0.
- Priorities: clrp+ldp on the same edge -> P=0. ldb+decb on the same edge -> B=data_in. Reset asserted mid-loop with B=3 -> B=0, P=0.
